// File: rtl/online_operand_feeder.sv
// Online operand feeder: serialises two signed-digit operands MSB-first,
// one {x,y} digit pair per fetch strobe, then appends ONLINE_DELAY zero
// pairs so the downstream online multiplier can flush, and pulses done.
module online_operand_feeder #(
   parameter int N            = 16,
   parameter int ONLINE_DELAY = 3,
   parameter int IDXW         = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            load,
   input  logic [N-1:0]    x_pos,
   input  logic [N-1:0]    x_neg,
   input  logic [N-1:0]    y_pos,
   input  logic [N-1:0]    y_neg,
   input  logic            enable_for_input,
   output logic            valid,
   output logic [1:0]      x_digit,
   output logic [1:0]      y_digit,
   output logic [IDXW-1:0] digit_idx,
   output logic            last,
   output logic            pad,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FEED = 2'd1,
      S_PAD  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Index of the last real digit and of the final (possibly padded) pair.
   // With ONLINE_DELAY=0 these coincide, which sends FEED straight to DONE.
   localparam logic [IDXW-1:0] LAST_REAL = IDXW'(N - 1);
   localparam logic [IDXW-1:0] LAST_IDX  = IDXW'(N + ONLINE_DELAY - 1);

   state_t          state_q, state_d;
   logic [N-1:0]    xp_q, xp_d;
   logic [N-1:0]    xn_q, xn_d;
   logic [N-1:0]    yp_q, yp_d;
   logic [N-1:0]    yn_q, yn_d;
   logic [IDXW-1:0] idx_q, idx_d;

   // Next-state, shift-register and index update for the feed sequence.
   always_comb begin
      state_d = state_q;
      xp_d    = xp_q;
      xn_d    = xn_q;
      yp_d    = yp_q;
      yn_d    = yn_q;
      idx_d   = idx_q;
      case (state_q)
         S_IDLE: begin
            if (load) begin
               // A position with both plus and minus set is the digit 0.
               xp_d    = x_pos & ~x_neg;
               xn_d    = x_neg & ~x_pos;
               yp_d    = y_pos & ~y_neg;
               yn_d    = y_neg & ~y_pos;
               idx_d   = '0;
               state_d = S_FEED;
            end
         end
         S_FEED: begin
            if (enable_for_input) begin
               xp_d = xp_q << 1;
               xn_d = xn_q << 1;
               yp_d = yp_q << 1;
               yn_d = yn_q << 1;
               // The index stops on the final pair so it stays readable in DONE.
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
                  if (idx_q == LAST_REAL) begin
                     state_d = S_PAD;
                  end
               end
            end
         end
         S_PAD: begin
            if (enable_for_input) begin
               if (idx_q == LAST_IDX) begin
                  state_d = S_DONE;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, operand shift registers and digit index; reset aborts any run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         xp_q    <= '0;
         xn_q    <= '0;
         yp_q    <= '0;
         yn_q    <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         xp_q    <= xp_d;
         xn_q    <= xn_d;
         yp_q    <= yp_d;
         yn_q    <= yn_d;
         idx_q   <= idx_d;
      end
   end

   // Outputs decode registered state only; no path from enable or load.
   assign valid     = (state_q == S_FEED) || (state_q == S_PAD);
   assign x_digit   = (state_q == S_FEED) ? {xp_q[N-1], xn_q[N-1]} : 2'b00;
   assign y_digit   = (state_q == S_FEED) ? {yp_q[N-1], yn_q[N-1]} : 2'b00;
   assign digit_idx = idx_q;
   assign last      = valid && (idx_q == LAST_IDX);
   assign pad       = (state_q == S_PAD);
   assign busy      = (state_q != S_IDLE);
   assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_online_operand_feeder.sv
// Scoreboard bench for online_operand_feeder: one N=4/D=3 instance and one
// N=2/D=0 instance. Expected digit pairs are queued when operands are loaded
// and popped when the feeder presents and the strobe consumes them.
module tb_online_operand_feeder;

   localparam int N4 = 4;
   localparam int D4 = 3;
   localparam int N2 = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       load4 = 1'b0, en4 = 1'b0;
   logic [3:0] xp4 = '0, xn4 = '0, yp4 = '0, yn4 = '0;
   logic       valid4, last4, pad4, busy4, done4;
   logic [1:0] x4, y4;
   logic [4:0] idx4;

   logic       load2 = 1'b0, en2 = 1'b0;
   logic [1:0] xp2 = '0, xn2 = '0, yp2 = '0, yn2 = '0;
   logic       valid2, last2, pad2, busy2, done2;
   logic [1:0] x2, y2;
   logic [2:0] idx2;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [1:0] x;
      logic [1:0] y;
      int         idx;
      logic       pd;
      logic       lst;
   } exp_t;

   exp_t sb[$];

   online_operand_feeder #(.N(4), .ONLINE_DELAY(3), .IDXW(5)) dut4 (
      .clk(clk), .rst_n(rst_n), .load(load4),
      .x_pos(xp4), .x_neg(xn4), .y_pos(yp4), .y_neg(yn4),
      .enable_for_input(en4), .valid(valid4), .x_digit(x4), .y_digit(y4),
      .digit_idx(idx4), .last(last4), .pad(pad4), .busy(busy4), .done(done4)
   );

   online_operand_feeder #(.N(2), .ONLINE_DELAY(0), .IDXW(3)) dut2 (
      .clk(clk), .rst_n(rst_n), .load(load2),
      .x_pos(xp2), .x_neg(xn2), .y_pos(yp2), .y_neg(yn2),
      .enable_for_input(en2), .valid(valid2), .x_digit(x2), .y_digit(y2),
      .digit_idx(idx2), .last(last2), .pad(pad2), .busy(busy2), .done(done2)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] enc(input logic p, input logic n);
      return (p && n) ? 2'b00 : {p, n};
   endfunction

   task automatic push4(input logic [3:0] xp, input logic [3:0] xn,
                        input logic [3:0] yp, input logic [3:0] yn);
      exp_t e;
      for (int i = 0; i < N4 + D4; i++) begin
         if (i < N4) begin
            e.x = enc(xp[N4-1-i], xn[N4-1-i]);
            e.y = enc(yp[N4-1-i], yn[N4-1-i]);
         end else begin
            e.x = 2'b00;
            e.y = 2'b00;
         end
         e.idx = i;
         e.pd  = (i >= N4);
         e.lst = (i == N4 + D4 - 1);
         sb.push_back(e);
      end
   endtask

   // Drives a one-cycle load; returns at the first cycle after the load edge.
   task automatic start4(input logic [3:0] xp, input logic [3:0] xn,
                         input logic [3:0] yp, input logic [3:0] yn, input logic en);
      @(negedge clk);
      xp4 = xp; xn4 = xn; yp4 = yp; yn4 = yn;
      load4 = 1'b1;
      en4 = en;
      @(negedge clk);
      load4 = 1'b0;
   endtask

   // Runs one operation on dut4 from cycle 1 after load. Strobes every
   // `period` cycles; optionally pulses load with other operands at glitch_idx.
   task automatic stream4(input string tag, input int period, input int glitch_idx,
                          output int done_cyc, output int last_strobe);
      int   cyc;
      bit   glitched;
      exp_t e;
      cyc = 1;
      glitched = 1'b0;
      done_cyc = -1;
      last_strobe = -1;
      while (cyc < 200) begin
         load4 = 1'b0;
         if (done4 === 1'b1) break;
         en4 = ((cyc % period) == 0);
         checks++;
         if (valid4 !== 1'b1) begin
            failures++;
            $display("FAIL %s valid cyc=%0d: got %b required 1", tag, cyc, valid4);
         end
         if (valid4 === 1'b1 && sb.size() > 0) begin
            e = sb[0];
            checks++;
            if ({x4, y4} !== {e.x, e.y}) begin
               failures++;
               $display("FAIL %s digits idx=%0d: got x=%b y=%b required x=%b y=%b",
                        tag, e.idx, x4, y4, e.x, e.y);
            end
            checks++;
            if (int'(idx4) !== e.idx) begin
               failures++;
               $display("FAIL %s digit_idx: got %0d required %0d", tag, idx4, e.idx);
            end
            checks++;
            if ({pad4, last4} !== {e.pd, e.lst}) begin
               failures++;
               $display("FAIL %s pad/last idx=%0d: got %b%b required %b%b",
                        tag, e.idx, pad4, last4, e.pd, e.lst);
            end
            if (glitch_idx >= 0 && !glitched && int'(idx4) == glitch_idx) begin
               load4 = 1'b1;
               xp4 = ~xp4; xn4 = 4'b0000; yp4 = ~yp4; yn4 = 4'b0000;
               glitched = 1'b1;
            end
            if (en4) begin
               void'(sb.pop_front());
               last_strobe = cyc;
            end
         end
         @(negedge clk);
         cyc++;
      end
      en4 = 1'b0;
      load4 = 1'b0;
      done_cyc = cyc;
      checks++;
      if (done4 !== 1'b1) begin
         failures++;
         $display("FAIL %s done timeout: got done=%b required 1", tag, done4);
      end
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL %s pairs left: got %0d unconsumed required 0", tag, sb.size());
      end
      checks++;
      if ({busy4, valid4} !== 2'b10) begin
         failures++;
         $display("FAIL %s busy/valid at done: got %b%b required 10", tag, busy4, valid4);
      end
      sb.delete();
   endtask

   task automatic expect_idle4(input string tag);
      @(negedge clk);
      checks++;
      if ({busy4, done4, valid4} !== 3'b000) begin
         failures++;
         $display("FAIL %s idle after done: got busy/done/valid=%b%b%b required 000",
                  tag, busy4, done4, valid4);
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      en4 = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({valid4, x4, y4, idx4, last4, pad4, busy4, done4} !== 15'b0) begin
         failures++;
         $display("FAIL reset dut4: got v=%b x=%b y=%b idx=%0d l=%b p=%b b=%b d=%b required all 0",
                  valid4, x4, y4, idx4, last4, pad4, busy4, done4);
      end
      checks++;
      if ({valid2, x2, y2, idx2, last2, pad2, busy2, done2} !== 12'b0) begin
         failures++;
         $display("FAIL reset dut2: got v=%b idx=%0d b=%b d=%b required all 0",
                  valid2, idx2, busy2, done2);
      end
      rst_n = 1'b1;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({valid4, busy4} !== 2'b00) begin
         failures++;
         $display("FAIL idle_enable: got valid/busy=%b%b required 00", valid4, busy4);
      end
      en4 = 1'b0;
   endtask

   task automatic test_continuous;
      int dc, ls;
      push4(4'b1001, 4'b0010, 4'b0100, 4'b1000);
      start4(4'b1001, 4'b0010, 4'b0100, 4'b1000, 1'b1);
      stream4("continuous", 1, -1, dc, ls);
      checks++;
      if (dc != 8) begin
         failures++;
         $display("FAIL continuous done cycle: got %0d required 8", dc);
      end
      checks++;
      if (int'(idx4) != N4 + D4 - 1) begin
         failures++;
         $display("FAIL continuous final idx: got %0d required %0d", idx4, N4 + D4 - 1);
      end
      expect_idle4("continuous");
   endtask

   task automatic test_strobed;
      int dc, ls;
      push4(4'b1001, 4'b0010, 4'b0100, 4'b1000);
      start4(4'b1001, 4'b0010, 4'b0100, 4'b1000, 1'b0);
      stream4("strobed", 3, -1, dc, ls);
      checks++;
      if (ls != 21 || dc != ls + 1) begin
         failures++;
         $display("FAIL strobed timing: got last strobe %0d done %0d required 21 22", ls, dc);
      end
      expect_idle4("strobed");
   endtask

   task automatic test_normalise;
      int dc, ls;
      push4(4'b1111, 4'b1111, 4'b0110, 4'b0011);
      start4(4'b1111, 4'b1111, 4'b0110, 4'b0011, 1'b1);
      stream4("normalise", 1, -1, dc, ls);
      checks++;
      if (dc != 8) begin
         failures++;
         $display("FAIL normalise done cycle: got %0d required 8", dc);
      end
      expect_idle4("normalise");
   endtask

   task automatic test_load_ignored;
      int dc, ls;
      push4(4'b0110, 4'b1001, 4'b0011, 4'b1100);
      start4(4'b0110, 4'b1001, 4'b0011, 4'b1100, 1'b1);
      stream4("load_busy", 1, 2, dc, ls);
      checks++;
      if (dc != 8) begin
         failures++;
         $display("FAIL load_busy done cycle: got %0d required 8", dc);
      end
      expect_idle4("load_busy");
   endtask

   task automatic test_back_to_back;
      int dc, ls;
      push4(4'b1010, 4'b0101, 4'b1100, 4'b0001);
      start4(4'b1010, 4'b0101, 4'b1100, 4'b0001, 1'b1);
      stream4("b2b_first", 1, -1, dc, ls);
      // Load during the DONE cycle must be ignored.
      xp4 = 4'b1111; xn4 = 4'b0000; yp4 = 4'b1111; yn4 = 4'b0000;
      load4 = 1'b1;
      @(negedge clk);
      checks++;
      if ({valid4, busy4} !== 2'b00) begin
         failures++;
         $display("FAIL b2b load_in_done: got valid/busy=%b%b required 00", valid4, busy4);
      end
      // Earliest accepted load: the IDLE cycle right after done.
      push4(4'b0001, 4'b1000, 4'b0010, 4'b0100);
      xp4 = 4'b0001; xn4 = 4'b1000; yp4 = 4'b0010; yn4 = 4'b0100;
      load4 = 1'b1;
      en4 = 1'b1;
      @(negedge clk);
      load4 = 1'b0;
      stream4("b2b_second", 1, -1, dc, ls);
      checks++;
      if (dc != 8) begin
         failures++;
         $display("FAIL b2b second done cycle: got %0d required 8", dc);
      end
      expect_idle4("b2b");
   endtask

   task automatic test_async_reset;
      int cyc, dc, ls;
      push4(4'b1001, 4'b0010, 4'b0100, 4'b1000);
      start4(4'b1001, 4'b0010, 4'b0100, 4'b1000, 1'b1);
      cyc = 1;
      while (cyc < 30 && !(pad4 === 1'b1 && idx4 === 5'd5)) begin
         @(negedge clk);
         cyc++;
      end
      checks++;
      if (pad4 !== 1'b1 || idx4 !== 5'd5) begin
         failures++;
         $display("FAIL async_reset reach PAD: got pad=%b idx=%0d required 1 5", pad4, idx4);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({valid4, x4, y4, idx4, last4, pad4, busy4, done4} !== 15'b0) begin
         failures++;
         $display("FAIL async_reset outputs: got v=%b idx=%0d p=%b b=%b d=%b required all 0",
                  valid4, idx4, pad4, busy4, done4);
      end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({done4, valid4, busy4} !== 3'b000) begin
            failures++;
            $display("FAIL async_reset held: got done/valid/busy=%b%b%b required 000",
                     done4, valid4, busy4);
         end
      end
      rst_n = 1'b1;
      sb.delete();
      push4(4'b0011, 4'b1100, 4'b1000, 4'b0001);
      start4(4'b0011, 4'b1100, 4'b1000, 4'b0001, 1'b1);
      stream4("after_reset", 1, -1, dc, ls);
      checks++;
      if (dc != 8) begin
         failures++;
         $display("FAIL after_reset done cycle: got %0d required 8", dc);
      end
      expect_idle4("after_reset");
   endtask

   task automatic test_no_delay;
      int   cyc, pairs;
      exp_t e;
      // X=(+1,-1), Y=(0,+1)
      e.x = 2'b10; e.y = 2'b00; e.idx = 0; e.pd = 1'b0; e.lst = 1'b0; sb.push_back(e);
      e.x = 2'b01; e.y = 2'b10; e.idx = 1; e.pd = 1'b0; e.lst = 1'b1; sb.push_back(e);
      @(negedge clk);
      xp2 = 2'b10; xn2 = 2'b01; yp2 = 2'b01; yn2 = 2'b00;
      load2 = 1'b1;
      en2 = 1'b1;
      @(negedge clk);
      load2 = 1'b0;
      cyc = 1;
      pairs = 0;
      while (cyc < 20 && done2 !== 1'b1) begin
         checks++;
         if (pad2 !== 1'b0) begin
            failures++;
            $display("FAIL no_delay pad: got %b required 0", pad2);
         end
         if (valid2 === 1'b1 && sb.size() > 0) begin
            e = sb.pop_front();
            pairs++;
            checks++;
            if ({x2, y2, last2} !== {e.x, e.y, e.lst} || int'(idx2) !== e.idx) begin
               failures++;
               $display("FAIL no_delay pair: got x=%b y=%b idx=%0d last=%b required x=%b y=%b idx=%0d last=%b",
                        x2, y2, idx2, last2, e.x, e.y, e.idx, e.lst);
            end
         end
         @(negedge clk);
         cyc++;
      end
      en2 = 1'b0;
      checks++;
      if (done2 !== 1'b1 || cyc != N2 + 1 || pairs != N2) begin
         failures++;
         $display("FAIL no_delay done: got done=%b cycle=%0d pairs=%0d required 1 %0d %0d",
                  done2, cyc, pairs, N2 + 1, N2);
      end
      @(negedge clk);
      checks++;
      if ({busy2, done2, valid2} !== 3'b000) begin
         failures++;
         $display("FAIL no_delay idle: got busy/done/valid=%b%b%b required 000",
                  busy2, done2, valid2);
      end
      sb.delete();
   endtask

   initial begin
      test_reset();
      test_continuous();
      test_strobed();
      test_normalise();
      test_load_ignored();
      test_back_to_back();
      test_async_reset();
      test_no_delay();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
